digits_input: RTL and testbench
===============================

// Module: digits_input
// PURPOSE
//   User-side counterpart of the 6-digit display path: three push-buttons enter a
//   6-digit decimal number, which is converted BCD->binary and handed to the CPU as
//   a `WORDSIZE value over a valid/ready handshake. Live BCD digits and cursor are
//   exported so the display driver can echo the entry while it is being edited.
// PARAMETERS
//   DEBOUNCE_CYCLES  1_000_000  stable-level cycles before a key change is accepted (20 ms @ 50 MHz)
// PORTS
//   clk         in   1          system clock; the only clock
//   rst         in   1          synchronous, active-high reset
//   key_inc_n   in   1          async button, active-low: increment digit under cursor
//   key_next_n  in   1          async button, active-low: move cursor one digit right
//   key_enter_n in   1          async button, active-low: commit entry
//   digits      out  24         live BCD, digit5 = [23:20] (most significant) .. digit0 = [3:0]
//   cursor      out  3          index of the digit being edited, 5..0
//   busy        out  1          1 in CONV or HOLD; key presses ignored
//   out_data    out  `WORDSIZE  converted value, stable while out_valid=1
//   out_valid   out  1          result available
//   out_ready   in   1          consumer accepts result
// BEHAVIOUR
//   - Reset values: digits=0, cursor=5, busy=0, out_data=0, out_valid=0, state=EDIT.
//   - Keys: 2-FF synchroniser, then debounce; a press is one 1-cycle pulse when the
//     synchronised level has been low for DEBOUNCE_CYCLES consecutive cycles. Holding
//     gives no repeat; release must also be stable DEBOUNCE_CYCLES before next press.
//   - FSM states: EDIT, CONV, HOLD.
//   - EDIT: inc pulse -> digit[cursor] +1, 9 wraps to 0. next pulse -> cursor -1, 0 wraps
//     to 5. inc and next in same cycle: increment applies to old cursor, then cursor moves.
//     enter pulse -> CONV, acc=0, index=5; inc/next in the same cycle are dropped.
//   - CONV: one digit per cycle, MSD first: acc <= (acc<<3)+(acc<<1)+digit[index].
//     Exactly 6 cycles; after the digit0 step go to HOLD with out_data loaded and
//     out_valid=1 in the first HOLD cycle (out_valid rises 7 cycles after enter pulse).
//   - acc is 20 bits (999_999 < 2^20). If `WORDSIZE >= 20, zero-extend; otherwise
//     result mapping per CONFIGURATION.
//   - HOLD: out_valid and out_data held until out_valid&&out_ready; that cycle
//     clears digits to 0, cursor to 5, out_valid to 0 (next cycle), state -> EDIT.
//     out_ready while out_valid=0 has no effect.
//   - Key pulses in CONV/HOLD are discarded, not queued. Debouncers keep running.
//   - rst in any state (incl. mid-CONV) aborts immediately to reset values.
// CONFIGURATION
//   DIGITS_INPUT_CLAMP_EN defined: when `WORDSIZE < 20 and acc > 2^`WORDSIZE-1,
//     out_data = all ones (saturate).
//   Not defined: out_data = acc[`WORDSIZE-1:0] (modulo truncation).
//   No effect when `WORDSIZE >= 20.
// STRUCTURE
//   - defines.h: `NUM_DIGITS 6, `BCD_W 4, `ACC_W 20, state encodings
//     `DI_EDIT/`DI_CONV/`DI_HOLD (2 bits).
//   - Sub-module key_debounce (params DEBOUNCE_CYCLES; ports clk, rst, key_n, press),
//     instanced 3x; resets to released state, counter 0, press 0.
//   - Top: edit datapath, FSM, shift-add converter, output register.
// TESTING (bench overrides DEBOUNCE_CYCLES=4)
//   - Reset: after rst, digits=0, cursor=5, out_valid=0; glitch of 2 cycles on key_inc_n
//     -> no change.
//   - Entry 123456: inc/next sequence -> digits=24'h123456, cursor wrapped to 5 after
//     sixth next; enter -> out_valid at pulse+7, out_data=123456.
//   - Wraps: 10 incs on digit5 -> digit5=0; next from cursor 0 -> 5; inc+next same
//     cycle at cursor 3 -> digit3+1, cursor 2.
//   - Handshake: out_ready=0 for 20 cycles -> out_valid/out_data stable, inc/enter
//     ignored; out_ready=1 -> accepted, digits=0, state EDIT.
//   - Overflow with `WORDSIZE=16, entry 999999: clamp build -> 16'hFFFF; plain build
//     -> 16'h423F.
//   - rst asserted in 3rd CONV cycle -> next cycle all outputs at reset values, no
//     out_valid.

Source files
------------

// File: rtl/digits_input_pkg.sv
// Shared constants and state type for the digits_input push-button entry block.
// `WORDSIZE sets the CPU word width (16 when the build does not define it).
`ifndef WORDSIZE
`define WORDSIZE 16
`endif

package digits_input_pkg;

    localparam int NUM_DIGITS = 6;
    localparam int BCD_W      = 4;
    localparam int ACC_W      = 20;
    localparam int WORDSIZE   = `WORDSIZE;

    typedef enum logic [1:0] {
        DI_EDIT = 2'd0,
        DI_CONV = 2'd1,
        DI_HOLD = 2'd2
    } di_state_e;

    function automatic logic [BCD_W-1:0] bcd_inc(input logic [BCD_W-1:0] d);
        return (d == 4'd9) ? 4'd0 : d + 4'd1;
    endfunction

    function automatic logic [2:0] cursor_right(input logic [2:0] c);
        return (c == 3'd0) ? 3'd5 : c - 3'd1;
    endfunction

endpackage

// File: rtl/digits_input_key_debounce.sv
// Button front end: 2-FF synchroniser plus level debouncer.
// Emits a single-cycle press pulse once a low level has been stable long enough.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic key_n,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic [1:0]    sync;
    logic          stable;
    logic [CW-1:0] cnt;

    // cnt counts consecutive cycles the synchronised level differs from stable
    always_ff @(posedge clk) begin
        if (rst) begin
            sync   <= 2'b11;
            stable <= 1'b1;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            sync  <= {sync[0], key_n};
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                cnt    <= '0;
                stable <= sync[1];
                press  <= ~sync[1];
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/digits_input.sv
// Six-digit BCD entry from three buttons, converted to binary for the CPU.
// Define DIGITS_INPUT_CLAMP_EN to saturate (instead of truncate) narrow results.
module digits_input
    import digits_input_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_inc_n,
    input  logic                key_next_n,
    input  logic                key_enter_n,
    output logic [23:0]         digits,
    output logic [2:0]          cursor,
    output logic                busy,
    output logic [WORDSIZE-1:0] out_data,
    output logic                out_valid,
    input  logic                out_ready
);

    logic inc_p, next_p, enter_p;

    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_inc (
        .clk(clk), .rst(rst), .key_n(key_inc_n), .press(inc_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
        .clk(clk), .rst(rst), .key_n(key_next_n), .press(next_p)
    );
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clk(clk), .rst(rst), .key_n(key_enter_n), .press(enter_p)
    );

    function automatic logic [WORDSIZE-1:0] fit(input logic [ACC_W-1:0] a);
`ifdef DIGITS_INPUT_CLAMP_EN
        if (WORDSIZE < ACC_W && (a >> WORDSIZE) != '0)
            return '1;
`endif
        return WORDSIZE'(a);
    endfunction

    di_state_e           state, state_n;
    logic [23:0]         digits_n;
    logic [2:0]          cursor_n, index, index_n;
    logic [ACC_W-1:0]    acc, acc_n;
    logic [WORDSIZE-1:0] out_data_n;
    logic                out_valid_n;
    logic [BCD_W-1:0]    d_cur, d_idx;

    assign d_cur = digits[{cursor, 2'b00} +: 4];
    assign d_idx = digits[{index, 2'b00} +: 4];
    assign busy  = (state != DI_EDIT);

    always_comb begin
        state_n     = state;
        digits_n    = digits;
        cursor_n    = cursor;
        index_n     = index;
        acc_n       = acc;
        out_data_n  = out_data;
        out_valid_n = out_valid;
        unique case (state)
            DI_EDIT: begin
                if (enter_p) begin
                    state_n = DI_CONV;
                    acc_n   = '0;
                    index_n = 3'd5;
                end else begin
                    if (inc_p)
                        digits_n[{cursor, 2'b00} +: 4] = bcd_inc(d_cur);
                    if (next_p)
                        cursor_n = cursor_right(cursor);
                end
            end
            DI_CONV: begin
                acc_n = (acc << 3) + (acc << 1) + {16'd0, d_idx};
                if (index == 3'd0) begin
                    state_n     = DI_HOLD;
                    out_data_n  = fit(acc_n);
                    out_valid_n = 1'b1;
                end else begin
                    index_n = index - 3'd1;
                end
            end
            DI_HOLD: begin
                if (out_valid && out_ready) begin
                    state_n     = DI_EDIT;
                    digits_n    = '0;
                    cursor_n    = 3'd5;
                    out_valid_n = 1'b0;
                end
            end
            default: state_n = DI_EDIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= DI_EDIT;
            digits    <= '0;
            cursor    <= 3'd5;
            index     <= 3'd5;
            acc       <= '0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_n;
            digits    <= digits_n;
            cursor    <= cursor_n;
            index     <= index_n;
            acc       <= acc_n;
            out_data  <= out_data_n;
            out_valid <= out_valid_n;
        end
    end

endmodule

// File: tb/tb_digits_input.sv
// Self-checking bench for digits_input with a short debounce window.
// Reference model keeps the entry as an array of decimal digits.
`timescale 1ns/1ps
module tb_digits_input;
    import digits_input_pkg::*;

    localparam int D = 4;
    localparam int W = WORDSIZE;

    logic         clk = 1'b0;
    logic         rst;
    logic         ki, kn, ke;
    logic [23:0]  digits;
    logic [2:0]   cursor;
    logic         busy;
    logic [W-1:0] out_data;
    logic         out_valid;
    logic         out_ready;

    digits_input #(.DEBOUNCE_CYCLES(D)) dut (
        .clk(clk), .rst(rst),
        .key_inc_n(ki), .key_next_n(kn), .key_enter_n(ke),
        .digits(digits), .cursor(cursor), .busy(busy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int md[6];
    int mc;

    typedef struct {
        logic [23:0] bcd;
        longint      dec;
    } vec_t;

    vec_t tbl[5];

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic logic [23:0] m_bcd();
        logic [23:0] b = '0;
        for (int i = 0; i < 6; i++)
            b[i*4 +: 4] = 4'(md[i]);
        return b;
    endfunction

    function automatic longint m_val();
        longint v = 0;
        for (int i = 5; i >= 0; i--)
            v = v * 10 + md[i];
        return v;
    endfunction

    function automatic longint m_out(input longint v);
        longint lim = (longint'(1) << W) - 1;
        if (W >= 20)
            return v;
`ifdef DIGITS_INPUT_CLAMP_EN
        if (v > lim)
            return lim;
`endif
        return v & lim;
    endfunction

    task automatic m_clear();
        for (int i = 0; i < 6; i++)
            md[i] = 0;
        mc = 5;
    endtask

    // one button action in EDIT, then compare DUT with the model
    task automatic do_op(input bit inc, input bit nxt);
        ki = ~inc;
        kn = ~nxt;
        tick(8);
        ki = 1'b1;
        kn = 1'b1;
        tick(8);
        if (inc) md[mc] = (md[mc] + 1) % 10;
        if (nxt) mc = (mc == 0) ? 5 : mc - 1;
        chk("digits", digits, m_bcd());
        chk("cursor", cursor, mc);
    endtask

    // press enter (optionally with inc in the same pulse) and wait for the result
    task automatic enter_conv(input string nm, input bit with_inc);
        out_ready = 1'b0;
        ke = 1'b0;
        ki = ~with_inc;
        tick(8);
        ke = 1'b1;
        ki = 1'b1;
        tick(4);
        chk({nm, "_valid_early"}, out_valid, 0);
        tick(1);
        chk({nm, "_valid"}, out_valid, 1);
        chk({nm, "_data"}, out_data, m_out(m_val()));
        chk({nm, "_busy"}, busy, 1);
        chk({nm, "_digits"}, digits, m_bcd());
        tick(8);
    endtask

    task automatic accept(input string nm);
        out_ready = 1'b1;
        tick(1);
        out_ready = 1'b0;
        m_clear();
        chk({nm, "_acc_valid"}, out_valid, 0);
        chk({nm, "_acc_digits"}, digits, 0);
        chk({nm, "_acc_cursor"}, cursor, 5);
        chk({nm, "_acc_busy"}, busy, 0);
    endtask

    task automatic enter_bcd(input logic [23:0] b);
        logic [23:0] v = b;
        for (int i = 5; i >= 0; i--) begin
            repeat (int'(v[i*4 +: 4])) do_op(1'b1, 1'b0);
            do_op(1'b0, 1'b1);
        end
    endtask

    initial begin
        logic [W-1:0] held;
        logic         seen;
        int           n;
        int           op;

        tbl[0] = '{24'h123456, 123456};
        tbl[1] = '{24'h999999, 999999};
        tbl[2] = '{24'h000000, 0};
        tbl[3] = '{24'h065536, 65536};
        tbl[4] = '{24'h090807, 90807};

        rst = 1'b1;
        ki = 1'b1;
        kn = 1'b1;
        ke = 1'b1;
        out_ready = 1'b0;
        m_clear();
        tick(3);
        chk("rst_digits", digits, 0);
        chk("rst_cursor", cursor, 5);
        chk("rst_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", out_data, 0);
        rst = 1'b0;
        tick(2);

        ki = 1'b0;
        tick(2);
        ki = 1'b1;
        tick(12);
        chk("glitch_digits", digits, 0);
        chk("glitch_cursor", cursor, 5);

        // table of full entries, each converted and accepted
        for (int t = 0; t < 5; t++) begin
            enter_bcd(tbl[t].bcd);
            chk("tbl_bcd", digits, tbl[t].bcd);
            chk("tbl_cursor", cursor, 5);
            enter_conv("tbl", 1'b0);
            chk("tbl_out", out_data, m_out(tbl[t].dec));
            accept("tbl");
        end

        repeat (10) do_op(1'b1, 1'b0);
        chk("wrap_d5", digits[23:20], 0);
        do_op(1'b1, 1'b0);
        do_op(1'b0, 1'b1);
        do_op(1'b0, 1'b1);
        do_op(1'b1, 1'b0);
        do_op(1'b1, 1'b1);
        chk("both_cursor", cursor, 2);
        chk("both_d3", digits[15:12], 2);

        // enter with a simultaneous inc: inc must be dropped
        enter_conv("enter_inc", 1'b1);

        held = out_data;
        out_ready = 1'b0;
        ki = 1'b0;
        tick(8);
        ki = 1'b1;
        ke = 1'b0;
        tick(8);
        ke = 1'b1;
        tick(8);
        chk("hold_valid", out_valid, 1);
        chk("hold_data", out_data, held);
        chk("hold_digits", digits, m_bcd());
        chk("hold_busy", busy, 1);
        accept("hold");

        // random edits against the model
        for (int r = 0; r < 4; r++) begin
            n = $urandom_range(8, 20);
            for (int k = 0; k < n; k++) begin
                out_ready = 1'($urandom_range(0, 1));
                op = $urandom_range(0, 2);
                do_op(op != 1, op != 0);
            end
            enter_conv("rand", 1'b0);
            accept("rand");
        end

        // reset during the third conversion cycle
        do_op(1'b1, 1'b0);
        do_op(1'b1, 1'b1);
        ke = 1'b0;
        tick(9);
        chk("conv_busy", busy, 1);
        rst = 1'b1;
        ke = 1'b1;
        tick(1);
        m_clear();
        chk("mid_digits", digits, 0);
        chk("mid_cursor", cursor, 5);
        chk("mid_busy", busy, 0);
        chk("mid_valid", out_valid, 0);
        chk("mid_data", out_data, 0);
        tick(9);
        rst = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 15; k++) begin
            tick(1);
            if (out_valid) seen = 1'b1;
        end
        chk("mid_no_valid", seen, 0);
        chk("mid_after_busy", busy, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
